// File: rtl/issue_pkg.sv
// Shared types for the multi-issue controller: register index, lane descriptor.
package issue_pkg;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    typedef struct packed {
        logic     priv;
        logic     mem;
        logic     load;
        logic     branch;
        reg_idx_t rs;
        reg_idx_t rt;
        logic     rt_used;
        logic     wb_en;
        reg_idx_t wb_dest;
    } issue_lane_t;

endpackage

// File: rtl/load_scoreboard.sv
// Per-register load-use countdown. A register is busy while its counter is nonzero;
// register 0 has no counter and is never busy.
module load_scoreboard
    import issue_pkg::*;
#(
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 3,
    parameter int NUM_SET  = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               flush,
    input  logic [NUM_SET-1:0] set_en,
    input  reg_idx_t           set_idx [NUM_SET],
    output logic [31:0]        busy
);

    assign busy[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_reg
            logic [CNT_W-1:0] cnt_reg;
            logic             hit;

            always_comb begin
                hit = 1'b0;
                for (int j = 0; j < NUM_SET; j++) begin
                    if (set_en[j] && (set_idx[j] == reg_idx_t'(gi))) begin
                        hit = 1'b1;
                    end
                end
            end

            // A new load to this register restarts the countdown even if it is mid-decrement.
            always_ff @(posedge clk) begin
                if (!resetn || flush) begin
                    cnt_reg <= '0;
                end else if (hit) begin
                    cnt_reg <= CNT_W'(LOAD_LAT);
                end else if (cnt_reg != '0) begin
                    cnt_reg <= cnt_reg - 1'b1;
                end
            end

            assign busy[gi] = (cnt_reg != '0);
        end
    endgenerate

endmodule

// File: rtl/multi_issue_engine.sv
// N-way in-order issue controller: thermometer issue mask from lane hazards,
// a registered load-use scoreboard and a saturating multi-issue counter.
module multi_issue_engine
    import issue_pkg::*;
#(
    parameter int ISSUE_WIDTH = 2,
    parameter int LOAD_LAT    = 2,
    parameter int CNT_W       = 3,
    parameter int FIFO_CNT_W  = 4,
    localparam int COUNT_W    = $clog2(ISSUE_WIDTH + 1)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     enable_master,
    input  logic                     flush,
    input  logic                     single_issue,
    input  logic [FIFO_CNT_W-1:0]    fifo_count,
    input  logic [ISSUE_WIDTH-1:0]   inst_priv,
    input  logic [ISSUE_WIDTH-1:0]   inst_mem,
    input  logic [ISSUE_WIDTH-1:0]   inst_load,
    input  logic [ISSUE_WIDTH-1:0]   inst_branch,
    input  logic [ISSUE_WIDTH*5-1:0] inst_rs,
    input  logic [ISSUE_WIDTH*5-1:0] inst_rt,
    input  logic [ISSUE_WIDTH-1:0]   inst_rt_used,
    input  logic [ISSUE_WIDTH-1:0]   inst_wb_en,
    input  logic [ISSUE_WIDTH*5-1:0] inst_wb_dest,
    output logic [ISSUE_WIDTH-1:0]   issue_en,
    output logic [COUNT_W-1:0]       issue_count,
    output logic [31:0]              multi_issue_cnt
);

    issue_lane_t              lanes   [ISSUE_WIDTH];
    reg_idx_t                 set_idx [ISSUE_WIDTH];
    logic [ISSUE_WIDTH-1:0]   set_en;
    logic [ISSUE_WIDTH-1:0]   lane_pass;
    logic [ISSUE_WIDTH-1:0]   lane_ok;
    logic [ISSUE_WIDTH-1:0]   sb_hazard;
    logic [31:0]              busy;
    logic                     multi_now;

    generate
        for (genvar gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_lane
            logic conflict;

            assign lanes[gi] = '{
                priv:    inst_priv[gi],
                mem:     inst_mem[gi],
                load:    inst_load[gi],
                branch:  inst_branch[gi],
                rs:      inst_rs[5*gi +: 5],
                rt:      inst_rt[5*gi +: 5],
                rt_used: inst_rt_used[gi],
                wb_en:   inst_wb_en[gi],
                wb_dest: inst_wb_dest[5*gi +: 5]
            };

            assign sb_hazard[gi] = busy[lanes[gi].rs] ||
                                   (lanes[gi].rt_used && busy[lanes[gi].rt]);

            // RAW/WAW against every older lane in the bundle that writes a real register.
            always_comb begin
                conflict = 1'b0;
                for (int j = 0; j < gi; j++) begin
                    if (lanes[j].wb_en && (lanes[j].wb_dest != REG_ZERO)) begin
                        if (lanes[j].wb_dest == lanes[gi].rs) begin
                            conflict = 1'b1;
                        end
                        if (lanes[gi].rt_used && (lanes[j].wb_dest == lanes[gi].rt)) begin
                            conflict = 1'b1;
                        end
                        if (lanes[gi].wb_en && (lanes[j].wb_dest == lanes[gi].wb_dest)) begin
                            conflict = 1'b1;
                        end
                    end
                end
            end

            if (gi == 0) begin : g_oldest
                assign lane_pass[gi] = enable_master && (fifo_count != '0) && !sb_hazard[gi];
            end else begin : g_younger
                assign lane_pass[gi] = !single_issue &&
                                       (int'(fifo_count) >= gi + 1) &&
                                       !(|inst_priv[gi:0]) &&
                                       !lanes[gi].mem && !lanes[gi].branch &&
                                       !sb_hazard[gi] && !conflict;
            end

            // Computed as an AND-reduction rather than a bit chain so each lane is a flat cone.
            assign lane_ok[gi] = &lane_pass[gi:0];

            assign set_en[gi]  = issue_en[gi] && lanes[gi].load && lanes[gi].wb_en &&
                                 (lanes[gi].wb_dest != REG_ZERO);
            assign set_idx[gi] = lanes[gi].wb_dest;
        end

        if (ISSUE_WIDTH > 1) begin : g_multi
            assign multi_now = issue_en[1];
        end else begin : g_single
            assign multi_now = 1'b0;
        end
    endgenerate

    assign issue_en = (resetn && !flush) ? lane_ok : '0;

    always_comb begin
        issue_count = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            issue_count = issue_count + COUNT_W'(issue_en[k]);
        end
    end

    load_scoreboard #(
        .LOAD_LAT (LOAD_LAT),
        .CNT_W    (CNT_W),
        .NUM_SET  (ISSUE_WIDTH)
    ) u_scoreboard (
        .clk     (clk),
        .resetn  (resetn),
        .flush   (flush),
        .set_en  (set_en),
        .set_idx (set_idx),
        .busy    (busy)
    );

    // Thermometer mask: two or more issued lanes is exactly lane 1 issuing.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            multi_issue_cnt <= '0;
        end else if (multi_now && (multi_issue_cnt != 32'hFFFF_FFFF)) begin
            multi_issue_cnt <= multi_issue_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_multi_issue_engine.sv
// Directed and random checks of multi_issue_engine against a ready-time reference model.
module tb_multi_issue_engine;

    localparam int W        = 2;
    localparam int LOAD_LAT = 2;

    logic           clk = 1'b0;
    logic           resetn;
    logic           enable_master;
    logic           flush;
    logic           single_issue;
    logic [3:0]     fifo_count;
    logic [W-1:0]   inst_priv, inst_mem, inst_load, inst_branch, inst_rt_used, inst_wb_en;
    logic [W*5-1:0] inst_rs, inst_rt, inst_wb_dest;
    logic [W-1:0]   issue_en;
    logic [1:0]     issue_count;
    logic [31:0]    multi_issue_cnt;

    int checks = 0;
    int errors = 0;

    // Model state: register r is unavailable in every cycle before ready_at[r].
    int          ready_at [32];
    int          cyc = 0;
    logic [31:0] exp_multi = 0;

    always #5 clk = ~clk;

    multi_issue_engine #(
        .ISSUE_WIDTH (W),
        .LOAD_LAT    (LOAD_LAT),
        .CNT_W       (3),
        .FIFO_CNT_W  (4)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .enable_master   (enable_master),
        .flush           (flush),
        .single_issue    (single_issue),
        .fifo_count      (fifo_count),
        .inst_priv       (inst_priv),
        .inst_mem        (inst_mem),
        .inst_load       (inst_load),
        .inst_branch     (inst_branch),
        .inst_rs         (inst_rs),
        .inst_rt         (inst_rt),
        .inst_rt_used    (inst_rt_used),
        .inst_wb_en      (inst_wb_en),
        .inst_wb_dest    (inst_wb_dest),
        .issue_en        (issue_en),
        .issue_count     (issue_count),
        .multi_issue_cnt (multi_issue_cnt)
    );

    function automatic bit is_busy(input int r);
        return (r != 0) && (cyc < ready_at[r]);
    endfunction

    function automatic logic [W-1:0] model_issue();
        logic [W-1:0] e = '0;
        bit chain = 1'b1;
        for (int k = 0; k < W; k++) begin
            int rs = int'(inst_rs[5*k +: 5]);
            int rt = int'(inst_rt[5*k +: 5]);
            int dk = int'(inst_wb_dest[5*k +: 5]);
            bit ok = !is_busy(rs) && !(inst_rt_used[k] && is_busy(rt));
            if (k == 0) begin
                ok = ok && enable_master && (fifo_count >= 1);
            end else begin
                ok = ok && !single_issue && (int'(fifo_count) >= k + 1) &&
                     !inst_mem[k] && !inst_branch[k];
                for (int j = 0; j <= k; j++) if (inst_priv[j]) ok = 0;
                for (int j = 0; j < k; j++) begin
                    int dj = int'(inst_wb_dest[5*j +: 5]);
                    if (inst_wb_en[j] && dj != 0) begin
                        if (dj == rs) ok = 0;
                        if (inst_rt_used[k] && dj == rt) ok = 0;
                        if (inst_wb_en[k] && dj == dk) ok = 0;
                    end
                end
            end
            chain = chain && ok;
            e[k]  = chain;
        end
        if (!resetn || flush) e = '0;
        return e;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: check at the falling edge, then advance the model across the rising edge.
    // exp_const >= 0 additionally pins issue_en to a hand-derived value.
    task automatic cycle(input string tag, input int exp_const);
        logic [W-1:0] e;
        int           n;
        @(negedge clk);
        e = model_issue();
        n = 0;
        for (int k = 0; k < W; k++) n += int'(e[k]);
        check_val({tag, ".issue_en"}, 32'(issue_en), 32'(e));
        check_val({tag, ".issue_count"}, 32'(issue_count), 32'(n));
        check_val({tag, ".multi_cnt"}, multi_issue_cnt, exp_multi);
        if (exp_const >= 0) check_val({tag, ".directed"}, 32'(issue_en), 32'(exp_const));
        $display("[%0t] %s en=%b cnt=%0d multi=%0d", $time, tag, issue_en, issue_count, multi_issue_cnt);
        @(posedge clk);
        if (!resetn || flush) begin
            for (int r = 0; r < 32; r++) ready_at[r] = 0;
        end else begin
            for (int k = 0; k < W; k++) begin
                int d = int'(inst_wb_dest[5*k +: 5]);
                if (e[k] && inst_load[k] && inst_wb_en[k] && d != 0) ready_at[d] = cyc + 1 + LOAD_LAT;
            end
        end
        if (!resetn) exp_multi = 0;
        else if (n >= 2 && exp_multi != 32'hFFFF_FFFF) exp_multi++;
        cyc++;
        #1;
    endtask

    task automatic clear_lanes();
        {inst_priv, inst_mem, inst_load, inst_branch, inst_rt_used, inst_wb_en} = '0;
        {inst_rs, inst_rt, inst_wb_dest} = '0;
    endtask

    task automatic set_lane(input int k, input bit ld, input bit br, input bit pv,
                            input int rs, input int rt, input bit rtu, input bit wb, input int dst);
        inst_priv[k]         = pv;
        inst_mem[k]          = ld;
        inst_load[k]         = ld;
        inst_branch[k]       = br;
        inst_rs[5*k +: 5]    = 5'(rs);
        inst_rt[5*k +: 5]    = 5'(rt);
        inst_rt_used[k]      = rtu;
        inst_wb_en[k]        = wb;
        inst_wb_dest[5*k +: 5] = 5'(dst);
    endtask

    task automatic two_indep();
        clear_lanes();
        set_lane(0, 0, 0, 0, 1, 2, 1, 1, 3);
        set_lane(1, 0, 0, 0, 4, 5, 1, 1, 6);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
        resetn = 0; enable_master = 1; flush = 0; single_issue = 0; fifo_count = 2;
        two_indep();
        cycle("reset0", 0);
        cycle("reset1", 0);
        resetn = 1;

        cycle("indep", 3);
        check_val("multi_after_indep", multi_issue_cnt, 32'd1);

        set_lane(0, 0, 0, 0, 1, 2, 1, 1, 8);
        set_lane(1, 0, 0, 0, 8, 5, 1, 1, 6);
        cycle("raw8", 1);
        set_lane(0, 0, 0, 0, 1, 2, 1, 1, 0);
        cycle("raw_zero", 3);

        clear_lanes(); fifo_count = 1;
        set_lane(0, 1, 0, 0, 1, 0, 0, 1, 9);
        cycle("load9", 1);
        set_lane(0, 0, 0, 0, 9, 0, 0, 1, 10);
        cycle("ld_t1", 0);
        cycle("ld_t2", 0);
        cycle("ld_t3", 1);

        set_lane(0, 1, 0, 0, 1, 0, 0, 1, 9);
        cycle("load9b", 1);
        set_lane(0, 0, 0, 0, 9, 0, 0, 1, 10);
        flush = 1;
        cycle("flush_t1", 0);
        flush = 0;
        cycle("flush_t2", 1);

        two_indep(); fifo_count = 3; single_issue = 1;
        cycle("single", 1);
        single_issue = 0; inst_priv[0] = 1;
        cycle("priv0", 1);
        inst_priv[0] = 0; inst_branch[1] = 1;
        cycle("branch1", 1);
        inst_branch[1] = 0; fifo_count = 1;
        cycle("fifo1", 1);

        clear_lanes(); fifo_count = 1;
        set_lane(0, 1, 0, 0, 1, 0, 0, 1, 9);
        cycle("load9c", 1);
        set_lane(0, 0, 0, 0, 9, 0, 0, 1, 10);
        enable_master = 0;
        cycle("stall_t1", 0);
        cycle("stall_t2", 0);
        enable_master = 1;
        cycle("stall_t3", 1);

        for (int i = 0; i < 400; i++) begin
            resetn        = ($urandom_range(0, 49) != 0);
            flush         = ($urandom_range(0, 19) == 0);
            enable_master = ($urandom_range(0, 9) != 0);
            single_issue  = ($urandom_range(0, 9) == 0);
            fifo_count    = 4'($urandom_range(0, 15));
            for (int k = 0; k < W; k++) begin
                bit ld = ($urandom_range(0, 2) == 0);
                set_lane(k, ld, !ld && ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                         $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
                         $urandom_range(0, 3) != 0, $urandom_range(0, 7));
                if (!ld) inst_mem[k] = ($urandom_range(0, 7) == 0);
            end
            cycle("rand", -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_issue_engine.md
Name: multi_issue_engine

Overview:
- N-way in-order issue controller for the decode/issue stage. Generalises the two-lane dual-issue check to ISSUE_WIDTH lanes.
- Adds a registered load-use scoreboard, a single-issue mode switch, flush handling and a multi-issue performance counter.
- Sits between the instruction FIFO and the ID/EX pipeline registers. Lane 0 is the oldest instruction in the bundle.
- Drives a thermometer-coded issue mask back to the FIFO pop logic and the pipeline enables.

Parameters:
- ISSUE_WIDTH, 2, number of issue lanes (legal values 1..4).
- LOAD_LAT, 2, cycles after issue during which a load's destination register is unavailable (1..7).
- CNT_W, 3, width of each scoreboard countdown counter (must satisfy 2^CNT_W > LOAD_LAT).
- FIFO_CNT_W, 4, width of the FIFO occupancy input.

Ports:
- clk  in  1  core clock. All state updates on its rising edge.
- resetn  in  1  synchronous, active-low reset.
- enable_master  in  1  pipeline advance enable. 0 means a downstream stall.
- flush  in  1  pipeline flush (exception or mispredict).
- single_issue  in  1  mode control: 1 restricts issue to lane 0 only.
- fifo_count  in  FIFO_CNT_W  number of valid instructions in the FIFO.
- inst_priv  in  ISSUE_WIDTH  per-lane privileged/CP0 instruction flag.
- inst_mem  in  ISSUE_WIDTH  per-lane memory-access flag.
- inst_load  in  ISSUE_WIDTH  per-lane load flag (implies inst_mem).
- inst_branch  in  ISSUE_WIDTH  per-lane branch/jump flag.
- inst_rs  in  ISSUE_WIDTH*5  per-lane rs field; lane k occupies bits [5k+4:5k].
- inst_rt  in  ISSUE_WIDTH*5  per-lane rt field.
- inst_rt_used  in  ISSUE_WIDTH  1 if lane k actually reads rt (R-type, store, branch compare).
- inst_wb_en  in  ISSUE_WIDTH  per-lane register writeback enable.
- inst_wb_dest  in  ISSUE_WIDTH*5  per-lane destination register.
- issue_en  out  ISSUE_WIDTH  thermometer issue mask; bit k=1 implies bits 0..k-1 are 1.
- issue_count  out  $clog2(ISSUE_WIDTH+1)  popcount of issue_en.
- multi_issue_cnt  out  32  count of cycles in which issue_count >= 2.

Behaviour:
- issue_en and issue_count are combinational from the inputs and the registered scoreboard. Zero-cycle decision latency.
- While resetn=0 or flush=1: issue_en=0 and issue_count=0.
- Scoreboard busy flags:
  - One CNT_W counter per architectural register 1..31.
  - busy[r] = (cnt[r] != 0).
  - Register 0 is never busy and never creates a hazard.
- Lane 0 issues iff all of the following hold:
  - enable_master = 1
  - fifo_count >= 1
  - rs0 is not busy
  - rt0 is not busy, if inst_rt_used[0] = 1
- Lane k > 0 issues iff all of the following hold:
  - issue_en[k-1] = 1
  - single_issue = 0
  - fifo_count >= k+1
  - inst_priv[j] = 0 for every j in 0..k
  - inst_mem[k] = 0 and inst_branch[k] = 0
  - no scoreboard hazard on rs_k, or on rt_k when rt is used
  - no intra-bundle RAW: for every j<k with inst_wb_en[j]=1 and dest_j != 0, dest_j != rs_k, and dest_j != rt_k when rt is used
  - no intra-bundle WAW: for every j<k with both writebacks enabled and a nonzero dest, dest_j != dest_k
- A failing lane blocks all younger lanes (in-order issue).
- Scoreboard update on each rising edge:
  - resetn=0 or flush=1: all counters cleared to 0.
  - Otherwise, for each issued lane k with inst_load[k]=1, inst_wb_en[k]=1 and dest_k != 0: cnt[dest_k] <= LOAD_LAT.
  - All other nonzero counters decrement by 1.
  - A set and a decrement of the same register in the same cycle: the set wins.
  - Two issued loads to the same dest cannot occur, because WAW blocks it.
- Counter semantics: LOAD_LAT=2 means a dependent instruction stalls in the two cycles after the load issues and may issue in the third.
- multi_issue_cnt:
  - Cleared on reset.
  - Increments on each rising edge where issue_count >= 2.
  - Saturates at 32'hFFFF_FFFF.
  - Not cleared by flush.
- ISSUE_WIDTH=1: single_issue has no effect, and multi_issue_cnt stays 0.
- fifo_count larger than ISSUE_WIDTH is legal and is treated as "enough entries".

Decomposition:
- Shared package issue_pkg:
  - reg_idx_t (5-bit register index)
  - REG_ZERO constant
  - issue_lane_t struct: priv, mem, load, branch, rs, rt, rt_used, wb_en, wb_dest
- Top-level lane vectors are unpacked into issue_lane_t internally.
- One sub-module, load_scoreboard: counter array, busy vector output, set/flush inputs. It is parametrised on LOAD_LAT, CNT_W and the number of set ports.

Test Plan:
- Reset, then fifo_count=2 with two independent ALU ops (lane0 dest $3, lane1 reads $4/$5) -> issue_en=2'b11, issue_count=2; multi_issue_cnt reaches 1 after the edge.
- Lane0 writes $8 and lane1 reads rs=$8 -> issue_en=2'b01. Repeat with lane0 dest $0 -> 2'b11.
- Load to $9 issued on lane 0 at cycle T, then a lane-0 instruction reading $9 -> issue_en=0 at T+1 and T+2, 2'b01 (or wider) at T+3.
- Load to $9 at cycle T, flush=1 at T+1 -> issue_en=0 at T+1; an instruction reading $9 issues at T+2.
- single_issue=1 with two independent ops and fifo_count=3 -> issue_en=2'b01. Also: inst_priv[0]=1 -> 2'b01, and inst_branch[1]=1 -> 2'b01.
- fifo_count=1 with two valid-looking lanes -> 2'b01. enable_master=0 -> issue_en=0 and the scoreboard still decrements.
